// File: rtl/oh_clockmux_ctrl.sv
// Break-before-make sequencer producing the one-hot enable vector for oh_clockmux.
// Switches drop the old enable, drain at all-zero, raise the new enable, then settle before done.
module oh_clockmux_ctrl #(
    parameter int N         = 4,
    parameter int DEFAULT   = 0,
    parameter int OFFCYCLES = 4,
    parameter int ONCYCLES  = 2,
    parameter int SW        = $clog2(N)
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic          req,
    input  logic [SW-1:0] sel,
    output logic [N-1:0]  en,
    output logic [SW-1:0] cur,
    output logic          busy,
    output logic          done,
    output logic          err
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DRAIN  = 2'b01,
        SETTLE = 2'b10
    } state_t;

    localparam int            MAXC     = (OFFCYCLES > ONCYCLES) ? OFFCYCLES : ONCYCLES;
    localparam int            CW       = $clog2(MAXC + 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFFCYCLES - 1);
    localparam logic [CW-1:0] ON_LOAD  = CW'(ONCYCLES - 1);
    localparam logic [SW-1:0] DEF_IDX  = SW'(DEFAULT);
    // One extra bit so a non-power-of-two N can be compared against every sel code.
    localparam logic [SW:0]   NLIM     = (SW + 1)'(N);

    function automatic logic [N-1:0] onehot(input logic [SW-1:0] idx);
        onehot = {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  en_d;
    logic [SW-1:0] cur_d;
    logic          busy_d, done_d, err_d;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            en      <= onehot(DEF_IDX);
            cur     <= DEF_IDX;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            en      <= en_d;
            cur     <= cur_d;
            busy    <= busy_d;
            done    <= done_d;
            err     <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
        en_d    = en;
        cur_d   = cur;
        busy_d  = busy;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if ({1'b0, sel} >= NLIM) begin
                        err_d = 1'b1;
                    end else if (sel == cur) begin
                        done_d = 1'b1;
                    end else begin
                        cur_d   = sel;
                        en_d    = '0;
                        busy_d  = 1'b1;
                        state_d = DRAIN;
                        cnt_d   = OFF_LOAD;
                    end
                end
            end
            DRAIN: begin
                en_d = '0;
                if (cnt_q == '0) begin
                    en_d    = onehot(cur);
                    state_d = SETTLE;
                    cnt_d   = ON_LOAD;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                // Unreachable encoding: recover to a consistent idle state on the committed clock.
                state_d = IDLE;
                en_d    = onehot(cur);
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_oh_clockmux_ctrl.sv
// Self-checking bench: timeline-based reference model for the N=4 instance, directed
// literal expectations, and an N=3 instance for the out-of-range path.
module tb_oh_clockmux_ctrl;
    localparam int N   = 4;
    localparam int OFF = 4;
    localparam int ON  = 2;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       req = 1'b0;
    logic [1:0] sel = '0;
    logic [3:0] en;
    logic [1:0] cur;
    logic       busy, done, err;

    logic       req3 = 1'b0;
    logic [1:0] sel3 = '0;
    logic [2:0] en3;
    logic [1:0] cur3;
    logic       busy3, done3, err3;

    int checks = 0;
    int failures = 0;

    oh_clockmux_ctrl #(.N(4), .DEFAULT(0), .OFFCYCLES(OFF), .ONCYCLES(ON)) u_dut (
        .clk(clk), .nreset(nreset), .req(req), .sel(sel),
        .en(en), .cur(cur), .busy(busy), .done(done), .err(err)
    );

    oh_clockmux_ctrl #(.N(3), .DEFAULT(0), .OFFCYCLES(OFF), .ONCYCLES(ON)) u_dut3 (
        .clk(clk), .nreset(nreset), .req(req3), .sel(sel3),
        .en(en3), .cur(cur3), .busy(busy3), .done(done3), .err(err3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference model: a switch is a timeline measured in edges from the accepting edge.
    logic [3:0] m_en = 4'b0001;
    int         m_cur = 0;
    bit         m_busy = 0, m_done = 0, m_err = 0;
    bit         m_valid = 0, m_rst_last = 0;
    int         edge_n = 0, t_acc = 0, k;

    always @(posedge clk) begin
        edge_n++;
        m_done = 0;
        m_err = 0;
        m_rst_last = !nreset;
        if (!nreset) begin
            m_en = 4'b0001; m_cur = 0; m_busy = 0; m_valid = 1;
        end else if (m_busy) begin
            k = edge_n - t_acc;
            if (k >= OFF) m_en = 4'(1 << m_cur);
            if (k == OFF + ON) begin m_busy = 0; m_done = 1; end
        end else if (req) begin
            if (int'(sel) >= N) m_err = 1;
            else if (int'(sel) == m_cur) m_done = 1;
            else begin
                t_acc = edge_n; m_cur = int'(sel); m_en = 4'b0000; m_busy = 1;
            end
        end
    end

    logic [3:0] prev_en = 4'b0000;
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_en", en, m_en);
            chk("model_cur", cur, m_cur);
            chk("model_busy", busy, m_busy);
            chk("model_done", done, m_done);
            chk("model_err", err, m_err);
            chk("en_onehot0", $onehot0(en), 1);
            chk("break_before_make", (!m_rst_last && prev_en != 0 && en != 0 && en != prev_en), 0);
            chk("done_err_excl", done && err, 0);
            prev_en = en;
        end
    end

    initial begin
        // Reset
        nreset = 1'b0;
        repeat (3) step();
        chk("rst_en", en, 4'b0001);
        chk("rst_cur", cur, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_en3", en3, 3'b001);

        // Switch to 2, with an ignored request while busy
        nreset = 1'b1; req = 1'b1; sel = 2'd2;
        step();                                   // t+1
        req = 1'b0; sel = 2'd3;
        chk("sw_en_t1", en, 4'b0000);
        chk("sw_busy_t1", busy, 1);
        step();                                   // t+2
        chk("sw_en_t2", en, 4'b0000);
        req = 1'b1; sel = 2'd1;
        step();                                   // t+3
        req = 1'b0;
        chk("sw_en_t3", en, 4'b0000);
        step();                                   // t+4
        chk("sw_en_t4", en, 4'b0000);
        step();                                   // t+5
        chk("sw_en_t5", en, 4'b0100);
        chk("sw_busy_t5", busy, 1);
        step();                                   // t+6
        chk("sw_busy_t6", busy, 1);
        chk("sw_done_t6", done, 0);
        step();                                   // t+7
        chk("sw_done_t7", done, 1);
        chk("sw_busy_t7", busy, 0);
        chk("sw_en_t7", en, 4'b0100);
        chk("sw_cur_t7", cur, 2);
        step();
        chk("sw_done_t8", done, 0);

        // Same-index request
        req = 1'b1; sel = 2'd2;
        step();
        req = 1'b0;
        chk("same_done", done, 1);
        chk("same_busy", busy, 0);
        chk("same_en", en, 4'b0100);
        step();
        chk("same_done_off", done, 0);
        chk("same_busy_off", busy, 0);

        // Out-of-range on the N=3 instance, then a legal switch there
        req3 = 1'b1; sel3 = 2'd3;
        step();
        req3 = 1'b0;
        chk("oor_err", err3, 1);
        chk("oor_done", done3, 0);
        chk("oor_en", en3, 3'b001);
        chk("oor_cur", cur3, 0);
        step();
        chk("oor_err_off", err3, 0);
        req3 = 1'b1; sel3 = 2'd2;
        step();
        req3 = 1'b0;
        chk("n3_busy", busy3, 1);
        chk("n3_en_drain", en3, 3'b000);
        repeat (6) step();
        chk("n3_done", done3, 1);
        chk("n3_en", en3, 3'b100);
        chk("n3_cur", cur3, 2);

        // Reset mid-DRAIN, then a normal switch to 3
        req = 1'b1; sel = 2'd1;
        step();                                   // t+1
        req = 1'b0;
        step();                                   // t+2
        nreset = 1'b0;
        step();                                   // t+3
        chk("mid_rst_en", en, 4'b0001);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cur", cur, 0);
        nreset = 1'b1; req = 1'b1; sel = 2'd3;
        step();
        req = 1'b0;
        repeat (4) step();                        // t+5
        chk("post_rst_en", en, 4'b1000);
        chk("post_rst_busy", busy, 1);
        repeat (2) step();                        // t+7
        chk("post_rst_done", done, 1);
        chk("post_rst_cur", cur, 3);

        // Random requests, occasional reset; the compare process checks every cycle
        for (int i = 0; i < 3000; i++) begin
            req    = ($urandom_range(0, 9) < 3);
            sel    = 2'($urandom_range(0, 3));
            nreset = ($urandom_range(0, 299) != 0);
            step();
        end
        nreset = 1'b1; req = 1'b0;
        repeat (10) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
